addr_window_gen: RTL and testbench

ADDR_WINDOW_GEN -- requirements
Module: addr_window_gen

---
 rtl/addr_window_pkg.sv | 40 ++++
 rtl/vga_timing_counter.sv | 43 ++++
 rtl/addr_window_gen.sv | 142 ++++++++++++++
 tb/tb_addr_window_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_window_pkg.sv
// Package shared by the window address generator and its timing counter.
// Holds the capture state encoding, the default VGA timing constants,
// the counter width and the window hit test used by the generator.
package addr_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_TOTAL  = 800;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_TOTAL  = 525;

    localparam int unsigned CNT_W = 10;

    // Window hit test. Sums are widened to 11 bits so origin+size never wraps.
    function automatic logic in_window(
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] y,
        input logic [CNT_W-1:0] w,
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] hc,
        input logic [CNT_W-1:0] vc,
        input logic [CNT_W:0]   h_act,
        input logic [CNT_W:0]   v_act
    );
        logic [CNT_W:0] x_end;
        logic [CNT_W:0] y_end;
        x_end = {1'b0, x} + {1'b0, w};
        y_end = {1'b0, y} + {1'b0, h};
        return (hc >= x) && ({1'b0, hc} < x_end) &&
               (vc >= y) && ({1'b0, vc} < y_end) &&
               ({1'b0, hc} < h_act) && ({1'b0, vc} < v_act);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counter.
//   clk, rst     : clock, asynchronous active-high reset
//   h_cnt        : pixel within line, 0..H_TOTAL-1
//   v_cnt        : line within frame, 0..V_TOTAL-1
//   frame_start  : position (0,0)
//   frame_end    : position (0,V_ACTIVE), first line after the visible area
module vga_timing_counter
    import addr_window_pkg::*;
#(
    parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_start,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        frame_start = (h_cnt == '0) && (v_cnt == '0);
        frame_end   = (h_cnt == '0) && (v_cnt == V_END);
    end

endmodule

// File: rtl/addr_window_gen.sv
// Window capture address generator. Arms on start, latches the window
// configuration at frame start, then emits one RAM write address per
// in-window pixel in raster order (one cycle latency).
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle pulse, arms a capture from IDLE
//   continuous          : 1 = re-arm after every frame
//   win_x/win_y         : window origin in pixels
//   win_w/win_h         : window size in pixels
//   base_addr           : RAM address of the first window pixel
//   ram_addr, we        : write address and its qualifier
//   busy                : capture armed or in progress
//   frame_done          : one-cycle pulse when a capture completes
module addr_window_gen
    import addr_window_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [9:0]        win_x,
    input  logic [9:0]        win_y,
    input  logic [9:0]        win_w,
    input  logic [9:0]        win_h,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              we,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W:0]    H_ACT    = (CNT_W + 1)'(H_ACTIVE);
    localparam logic [CNT_W:0]    V_ACT    = (CNT_W + 1)'(V_ACTIVE);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              frame_start;
    logic              frame_end;

    state_t            state;
    logic [9:0]        sh_x;
    logic [9:0]        sh_y;
    logic [9:0]        sh_w;
    logic [9:0]        sh_h;
    logic              sh_cont;
    logic [ADDR_W-1:0] acc;

    logic              live_hit;
    logic              shadow_hit;

    vga_timing_counter #(
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    always_comb begin
        live_hit   = in_window(win_x, win_y, win_w, win_h, h_cnt, v_cnt, H_ACT, V_ACT);
        shadow_hit = in_window(sh_x, sh_y, sh_w, sh_h, h_cnt, v_cnt, H_ACT, V_ACT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sh_x       <= '0;
            sh_y       <= '0;
            sh_w       <= '0;
            sh_h       <= '0;
            sh_cont    <= 1'b0;
            acc        <= '0;
            ram_addr   <= '0;
            we         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ARMED;
                        busy  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (frame_start) begin
                        state   <= ST_CAPTURE;
                        sh_x    <= win_x;
                        sh_y    <= win_y;
                        sh_w    <= win_w;
                        sh_h    <= win_h;
                        sh_cont <= continuous;
                        // Pixel (0,0) is the latch cycle itself; test it against
                        // the live config so a window at the origin is not missed.
                        if (live_hit) begin
                            we       <= 1'b1;
                            ram_addr <= base_addr;
                            acc      <= base_addr + ADDR_ONE;
                        end else begin
                            acc      <= base_addr;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (frame_end) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                        // Stays high through DONE when about to re-arm, so a
                        // continuous capture shows an unbroken busy.
                        busy       <= sh_cont;
                    end else if (shadow_hit) begin
                        we       <= 1'b1;
                        ram_addr <= acc;
                        acc      <= acc + ADDR_ONE;
                    end
                end
                ST_DONE: begin
                    state <= sh_cont ? ST_ARMED : ST_IDLE;
                    busy  <= sh_cont;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_window_gen.sv
// Directed scoreboard bench for addr_window_gen on a reduced 16x8 raster
// (10x6 visible). Expected writes {addr, x, y} are queued when a capture is
// armed and popped as the DUT asserts we.
module tb_addr_window_gen;

    localparam int H_ACTIVE = 10;
    localparam int H_TOTAL  = 16;
    localparam int V_ACTIVE = 6;
    localparam int V_TOTAL  = 8;
    localparam int ADDR_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic [9:0]        win_x = '0;
    logic [9:0]        win_y = '0;
    logic [9:0]        win_w = '0;
    logic [9:0]        win_h = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              we;
    logic              busy;
    logic              frame_done;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int wr_count = 0;

    int th = 0, tv = 0, ph = 0, pv = 0;

    logic [35:0] exp_q[$];

    addr_window_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .win_x      (win_x),
        .win_y      (win_y),
        .win_w      (win_w),
        .win_h      (win_h),
        .base_addr  (base_addr),
        .ram_addr   (ram_addr),
        .we         (we),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Independent raster position; ph/pv is the pixel of the previous cycle,
    // which is the pixel a write seen now belongs to.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            th = 0; tv = 0; ph = 0; pv = 0;
        end else begin
            ph = th; pv = tv;
            if (th == H_TOTAL - 1) begin
                th = 0;
                tv = (tv == V_TOTAL - 1) ? 0 : tv + 1;
            end else begin
                th = th + 1;
            end
        end
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        logic [35:0] got;
        logic [35:0] exp;
        if (!rst) begin
            if (frame_done === 1'b1) fd_count++;
            if (we === 1'b1) begin
                wr_count++;
                got = {ram_addr, 10'(ph), 10'(pv)};
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_write: observed addr %0h at (%0d,%0d), expected no write",
                           ram_addr, ph, pv);
                end
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    checks++;
                    assert (got === exp) else begin
                        errors++;
                        $error("FAIL write: observed addr %0h at (%0d,%0d), expected addr %0h at (%0d,%0d)",
                               got[35:20], got[19:10], got[9:0], exp[35:20], exp[19:10], exp[9:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: raster-order writes of the window clipped to the visible area.
    task automatic push_window(input int x, input int y, input int w, input int h,
                               input logic [15:0] base);
        logic [15:0] a;
        a = base;
        for (int yy = y; yy < y + h; yy++) begin
            for (int xx = x; xx < x + w; xx++) begin
                if (xx < H_ACTIVE && yy < V_ACTIVE) begin
                    exp_q.push_back({a, 10'(xx), 10'(yy)});
                    a = a + 16'd1;
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            check("busy_held", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_fd(input int target, input int budget, input bit chk_busy);
        int n;
        n = 0;
        while (fd_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
            if (chk_busy && fd_count < target) check("busy_held", 32'(busy), 32'd1);
        end
        check("frame_done_reached", 32'(fd_count >= target), 32'd1);
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n;
        n = 0;
        while (wr_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("write_reached", 32'(wr_count >= target), 32'd1);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic set_win(input int x, input int y, input int w, input int h,
                           input logic [15:0] base, input logic cont);
        win_x = 10'(x); win_y = 10'(y); win_w = 10'(w); win_h = 10'(h);
        base_addr = base; continuous = cont;
    endtask

    initial begin
        int fd0, wr0;

        // Reset state
        wait_cycles(3);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // Single frame, start coincident with the first frame start
        set_win(2, 1, 3, 2, 16'd100, 1'b0);
        push_window(2, 1, 3, 2, 16'd100);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("armed_at_frame_start", 32'(busy), 32'd1);
        wait_cycles(100);
        check("no_capture_first_frame", 32'(wr_count), 32'd0);
        wait_fd(1, 400, 1'b0);
        wait_cycles(3);
        check("single_busy_clear", 32'(busy), 32'd0);
        check("single_queue_empty", 32'(exp_q.size()), 32'd0);
        check("single_write_count", 32'(wr_count), 32'd6);
        check("single_hold_addr", 32'(ram_addr), 32'd105);
        wait_cycles(150);
        check("single_no_rearm_writes", 32'(wr_count), 32'd6);
        check("single_one_done", 32'(fd_count), 32'd1);

        // Continuous for three frames; continuous cleared after the second latch
        fd0 = fd_count; wr0 = wr_count;
        set_win(2, 1, 3, 2, 16'd100, 1'b1);
        for (int f = 0; f < 3; f++) push_window(2, 1, 3, 2, 16'd100);
        pulse_start();
        wait_fd(fd0 + 1, 400, 1'b1);
        wait_busy(40);
        continuous = 1'b0;
        wait_fd(fd0 + 3, 400, 1'b1);
        wait_cycles(3);
        check("cont_busy_clear", 32'(busy), 32'd0);
        wait_cycles(260);
        check("cont_three_done", 32'(fd_count - fd0), 32'd3);
        check("cont_write_count", 32'(wr_count - wr0), 32'd18);
        check("cont_queue_empty", 32'(exp_q.size()), 32'd0);

        // Clipped window; config scrambled mid-capture must not matter
        fd0 = fd_count; wr0 = wr_count;
        set_win(8, 4, 5, 5, 16'd100, 1'b0);
        push_window(8, 4, 5, 5, 16'd100);
        pulse_start();
        wait_wr(wr0 + 1, 400);
        set_win(0, 0, 10, 6, 16'd500, 1'b1);
        wait_fd(fd0 + 1, 400, 1'b0);
        continuous = 1'b0;
        wait_cycles(3);
        check("clip_write_count", 32'(wr_count - wr0), 32'd4);
        check("clip_queue_empty", 32'(exp_q.size()), 32'd0);
        check("clip_busy_clear", 32'(busy), 32'd0);

        // Address wrap
        fd0 = fd_count; wr0 = wr_count;
        set_win(4, 3, 3, 1, 16'hFFFE, 1'b0);
        push_window(4, 3, 3, 1, 16'hFFFE);
        pulse_start();
        wait_fd(fd0 + 1, 400, 1'b0);
        wait_cycles(3);
        check("wrap_write_count", 32'(wr_count - wr0), 32'd3);
        check("wrap_hold_addr", 32'(ram_addr), 32'd0);
        check("wrap_we_low", 32'(we), 32'd0);

        // Zero-width window
        fd0 = fd_count; wr0 = wr_count;
        set_win(2, 1, 0, 2, 16'd100, 1'b0);
        pulse_start();
        wait_fd(fd0 + 1, 400, 1'b0);
        wait_cycles(140);
        check("zero_w_no_writes", 32'(wr_count - wr0), 32'd0);
        check("zero_w_one_done", 32'(fd_count - fd0), 32'd1);

        // Reset after the third write, then restart
        fd0 = fd_count; wr0 = wr_count;
        set_win(2, 1, 3, 2, 16'd100, 1'b0);
        push_window(2, 1, 3, 2, 16'd100);
        pulse_start();
        wait_wr(wr0 + 3, 400);
        rst = 1'b1;
        #1;
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_ram_addr", 32'(ram_addr), 32'd0);
        exp_q.delete();
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(300);
        check("midrst_no_done", 32'(fd_count - fd0), 32'd0);
        check("midrst_needs_start", 32'(busy), 32'd0);
        check("midrst_no_writes", 32'(wr_count - wr0), 32'd3);
        wr0 = wr_count;
        push_window(2, 1, 3, 2, 16'd100);
        pulse_start();
        wait_fd(fd0 + 1, 400, 1'b0);
        wait_cycles(3);
        check("restart_write_count", 32'(wr_count - wr0), 32'd6);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
